// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the parallel XNOR LFSR pattern generator and checker.
//   lfsr_taps(width)        : tap mask for a width; bit t-1 is set for tap t
//   lfsr_ones(width)        : all-ones word for a width (the XNOR lockup word)
//   lfsr_next(width, value) : one LFSR step, {v[N-2:0], fb}
//   chk_state_t             : checker state enum {SEARCH, LOCKED}
// Widths 3..32 are supported. Values are carried in 32-bit containers, and
// callers truncate the result to their own width.
// -----------------------------------------------------------------------------
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_BITS = 32;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  function automatic logic [31:0] lfsr_taps(input int unsigned width);
    logic [31:0] m;
    case (width)
      3:       m = 32'h0000_0006;  // 3,2
      4:       m = 32'h0000_000C;  // 4,3
      5:       m = 32'h0000_0014;  // 5,3
      6:       m = 32'h0000_0030;  // 6,5
      7:       m = 32'h0000_0060;  // 7,6
      8:       m = 32'h0000_00B8;  // 8,6,5,4
      9:       m = 32'h0000_0110;  // 9,5
      10:      m = 32'h0000_0240;  // 10,7
      11:      m = 32'h0000_0500;  // 11,9
      12:      m = 32'h0000_0829;  // 12,6,4,1
      13:      m = 32'h0000_100D;  // 13,4,3,1
      14:      m = 32'h0000_2015;  // 14,5,3,1
      15:      m = 32'h0000_6000;  // 15,14
      16:      m = 32'h0000_D008;  // 16,15,13,4
      17:      m = 32'h0001_2000;  // 17,14
      18:      m = 32'h0002_0400;  // 18,11
      19:      m = 32'h0004_0023;  // 19,6,2,1
      20:      m = 32'h0009_0000;  // 20,17
      21:      m = 32'h0014_0000;  // 21,19
      22:      m = 32'h0030_0000;  // 22,21
      23:      m = 32'h0042_0000;  // 23,18
      24:      m = 32'h00E1_0000;  // 24,23,22,17
      25:      m = 32'h0120_0000;  // 25,22
      26:      m = 32'h0200_0023;  // 26,6,2,1
      27:      m = 32'h0400_0013;  // 27,5,2,1
      28:      m = 32'h0900_0000;  // 28,25
      29:      m = 32'h1400_0000;  // 29,27
      30:      m = 32'h2000_0029;  // 30,6,4,1
      31:      m = 32'h4800_0000;  // 31,28
      32:      m = 32'h8020_0003;  // 32,22,2,1
      default: m = 32'h0000_0000;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] lfsr_ones(input int unsigned width);
    if (width >= LFSR_MAX_BITS)
      return 32'hFFFF_FFFF;
    return (32'h1 << width) - 32'h1;
  endfunction

  // Feedback is a left-to-right XNOR chain over the tapped bits.
  function automatic logic [31:0] lfsr_next(input int unsigned width,
                                            input logic [31:0] value);
    logic [31:0] taps;
    logic [31:0] mask;
    logic [31:0] v;
    logic        fb;
    logic        first;
    taps  = lfsr_taps(width);
    mask  = lfsr_ones(width);
    v     = value & mask;
    fb    = 1'b0;
    first = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (taps[i]) begin
        fb    = first ? v[i] : ~(fb ^ v[i]);
        first = 1'b0;
      end
    end
    return ((v << 1) | {31'b0, fb}) & mask;
  endfunction

endpackage

// File: rtl/lfsr_checker.sv
// -----------------------------------------------------------------------------
// lfsr_checker
// Receive-side PRBS checker for the parallel XNOR LFSR generator. The checker
// self-synchronises to the incoming word stream. It then predicts every
// following word from a free-running internal copy of the LFSR, and flags and
// counts the words that mismatch.
//
// Ports
//   i_Clk        clock
//   i_Rst_L      asynchronous active-low reset
//   i_Enable     i_Data valid this cycle
//   i_Data       received LFSR word [NUM_BITS-1:0]
//   i_Clear      synchronous clear of the error counter(s)
//   o_Locked     checker is locked to the sequence
//   o_Err_Pulse  one-cycle pulse: last enabled word mismatched while locked
//   o_Err_Count  saturating mismatched-word count [ERR_WIDTH-1:0]
//   o_Bit_Err_Count  (only with LFSR_CHK_BITERR_EN) saturating sum of
//                    mismatched bits over locked enabled cycles
//
// Build option: define LFSR_CHK_BITERR_EN to add o_Bit_Err_Count.
//
// state  | meaning
// -------+----------------------------------------------------------------
// SEARCH | seeding from received words; counts consecutive correct steps
// LOCKED | comparing against the free-running prediction; counts misses
// -----------------------------------------------------------------------------
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned NUM_BITS   = 8,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 4,
  parameter int unsigned ERR_WIDTH  = 16
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Enable,
  input  logic [NUM_BITS-1:0]  i_Data,
  input  logic                 i_Clear,
  output logic                 o_Locked,
  output logic                 o_Err_Pulse,
  output logic [ERR_WIDTH-1:0] o_Err_Count
`ifdef LFSR_CHK_BITERR_EN
  ,
  output logic [ERR_WIDTH-1:0] o_Bit_Err_Count
`endif
);

  localparam int unsigned MW = $clog2(LOCK_COUNT + 1);
  localparam int unsigned LW = $clog2(LOSS_COUNT + 1);

  localparam logic [NUM_BITS-1:0] LOCKUP    = NUM_BITS'(lfsr_ones(NUM_BITS));
  localparam logic [MW-1:0]       LOCK_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [LW-1:0]       LOSS_LAST = LW'(LOSS_COUNT - 1);

  chk_state_t          state;
  logic [NUM_BITS-1:0] prev_word;
  logic                prev_valid;
  logic [NUM_BITS-1:0] exp_word;
  logic [MW-1:0]       match_cnt;
  logic [LW-1:0]       miss_cnt;

  logic [NUM_BITS-1:0] next_of_data;
  logic [NUM_BITS-1:0] next_of_prev;
  logic [NUM_BITS-1:0] next_of_exp;
  logic                search_hit;
  logic                locked_miss;
  logic                count_err;

  assign next_of_data = NUM_BITS'(lfsr_next(NUM_BITS, 32'(i_Data)));
  assign next_of_prev = NUM_BITS'(lfsr_next(NUM_BITS, 32'(prev_word)));
  assign next_of_exp  = NUM_BITS'(lfsr_next(NUM_BITS, 32'(exp_word)));

  // The lockup word maps to itself, so it would otherwise "match" forever.
  assign search_hit  = prev_valid && (i_Data == next_of_prev) && (i_Data != LOCKUP);
  assign locked_miss = (i_Data != exp_word);
  assign count_err   = i_Enable && (state == LOCKED) && locked_miss;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state       <= SEARCH;
      prev_word   <= '0;
      prev_valid  <= 1'b0;
      exp_word    <= '0;
      match_cnt   <= '0;
      miss_cnt    <= '0;
      o_Locked    <= 1'b0;
      o_Err_Pulse <= 1'b0;
    end else begin
      o_Err_Pulse <= 1'b0;
      if (i_Enable) begin
        case (state)
          SEARCH: begin
            prev_word  <= i_Data;
            prev_valid <= 1'b1;
            if (search_hit) begin
              match_cnt <= match_cnt + 1'b1;
              if (match_cnt == LOCK_LAST) begin
                state    <= LOCKED;
                o_Locked <= 1'b1;
                exp_word <= next_of_data;
                miss_cnt <= '0;
              end
            end else begin
              match_cnt <= '0;
            end
          end
          LOCKED: begin
            // Prediction free-runs: received data never reseeds it.
            exp_word <= next_of_exp;
            if (locked_miss) begin
              o_Err_Pulse <= 1'b1;
              if (miss_cnt == LOSS_LAST) begin
                state      <= SEARCH;
                o_Locked   <= 1'b0;
                prev_word  <= i_Data;
                prev_valid <= 1'b1;
                match_cnt  <= '0;
                miss_cnt   <= '0;
              end else begin
                miss_cnt <= miss_cnt + 1'b1;
              end
            end else begin
              miss_cnt <= '0;
            end
          end
          default: begin
            state    <= SEARCH;
            o_Locked <= 1'b0;
          end
        endcase
      end
    end
  end

  // Clear wins over a coincident increment.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)
      o_Err_Count <= '0;
    else if (i_Clear)
      o_Err_Count <= '0;
    else if (count_err && !(&o_Err_Count))
      o_Err_Count <= o_Err_Count + 1'b1;
  end

`ifdef LFSR_CHK_BITERR_EN
  localparam int unsigned PW = $clog2(NUM_BITS + 1);
  localparam int unsigned SW = ((ERR_WIDTH > PW) ? ERR_WIDTH : PW) + 1;
  localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;

  function automatic logic [ERR_WIDTH-1:0] sat_add(input logic [ERR_WIDTH-1:0] a,
                                                   input logic [PW-1:0]        b);
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SW'(ERR_MAX))
      return ERR_MAX;
    return s[ERR_WIDTH-1:0];
  endfunction

  logic [NUM_BITS-1:0] diff_bits;
  logic [PW-1:0]       bit_errs;

  assign diff_bits = i_Data ^ exp_word;

  always_comb begin
    bit_errs = '0;
    for (int i = 0; i < int'(NUM_BITS); i++)
      bit_errs = bit_errs + PW'(diff_bits[i]);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)
      o_Bit_Err_Count <= '0;
    else if (i_Clear)
      o_Bit_Err_Count <= '0;
    else if (i_Enable && (state == LOCKED))
      o_Bit_Err_Count <= sat_add(o_Bit_Err_Count, bit_errs);
  end
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Directed bench for lfsr_checker at NUM_BITS=5 (taps 5,3).
// dut     : LOCK_COUNT=4, LOSS_COUNT=4, ERR_WIDTH=16
// dut_sat : LOCK_COUNT=4, LOSS_COUNT=8, ERR_WIDTH=2 (saturation/clear checks)
// Both instances share the same stimulus.
`timescale 1ns/1ps
module tb_lfsr_checker;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [4:0] data;
  logic       clr;

  logic        locked, pulse;
  logic [15:0] cnt;
  logic        locked_s, pulse_s;
  logic [1:0]  cnt_s;
`ifdef LFSR_CHK_BITERR_EN
  logic [15:0] bcnt;
  logic [1:0]  bcnt_s;
`endif

  int n_chk = 0;
  int n_bad = 0;

  // Hand-stepped XNOR sequence for taps {5,3}, starting at 0x00 (period 31).
  logic [4:0] seq [31] = '{5'h00, 5'h01, 5'h03, 5'h07, 5'h0E, 5'h1C, 5'h19, 5'h12,
                           5'h04, 5'h08, 5'h11, 5'h02, 5'h05, 5'h0A, 5'h15, 5'h0B,
                           5'h17, 5'h0F, 5'h1E, 5'h1D, 5'h1B, 5'h16, 5'h0D, 5'h1A,
                           5'h14, 5'h09, 5'h13, 5'h06, 5'h0C, 5'h18, 5'h10};

  lfsr_checker #(.NUM_BITS(5), .LOCK_COUNT(4), .LOSS_COUNT(4), .ERR_WIDTH(16)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Data(data), .i_Clear(clr),
    .o_Locked(locked), .o_Err_Pulse(pulse), .o_Err_Count(cnt)
`ifdef LFSR_CHK_BITERR_EN
    , .o_Bit_Err_Count(bcnt)
`endif
  );

  lfsr_checker #(.NUM_BITS(5), .LOCK_COUNT(4), .LOSS_COUNT(8), .ERR_WIDTH(2)) dut_sat (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_Data(data), .i_Clear(clr),
    .o_Locked(locked_s), .o_Err_Pulse(pulse_s), .o_Err_Count(cnt_s)
`ifdef LFSR_CHK_BITERR_EN
    , .o_Bit_Err_Count(bcnt_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive at posedge+1, return at next posedge+1.
  task automatic step(input logic e, input logic [4:0] d, input logic c);
    en   = e;
    data = d;
    clr  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en    = 1'b0;
    data  = 5'h00;
    clr   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic lock_up();
    for (int i = 0; i < 5; i++) step(1'b1, seq[i], 1'b0);
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b0;
    data  = 5'h00;
    clr   = 1'b0;
    #2;

    // ---- 1: reset state, then lock on 0x00,0x01,0x03,0x07,0x0E
    do_reset();
    chk("rst_locked", 32'(locked), 0);
    chk("rst_pulse",  32'(pulse),  0);
    chk("rst_count",  32'(cnt),    0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, seq[i], 1'b0);
      chk($sformatf("pre_lock%0d", i), 32'(locked), 0);
    end
    step(1'b1, seq[4], 1'b0);
    chk("lock_rise",  32'(locked), 1);
    chk("lock_count", 32'(cnt),    0);

    // ---- 2: single corrupted word (0x1D instead of 0x1C), then correct
    step(1'b1, 5'h1D, 1'b0);
    chk("t2_pulse",  32'(pulse),  1);
    chk("t2_count",  32'(cnt),    1);
    chk("t2_locked", 32'(locked), 1);
`ifdef LFSR_CHK_BITERR_EN
    chk("t2_bitcnt", 32'(bcnt), 1);
`endif
    for (int i = 6; i < 11; i++) begin
      step(1'b1, seq[i], 1'b0);
      chk($sformatf("t2_nopulse%0d", i), 32'(pulse), 0);
    end
    chk("t2_count_hold", 32'(cnt),    1);
    chk("t2_still_lock", 32'(locked), 1);

    // ---- 3: lockup word never locks
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 5'h1F, 1'b0);
      chk($sformatf("t3_nolock%0d", i), 32'(locked), 0);
    end
    chk("t3_count", 32'(cnt), 0);

    // ---- 4: phase jump -> 4 misses, loss of lock, relock on new phase
    do_reset();
    lock_up();
    for (int i = 5; i < 8; i++) step(1'b1, seq[i], 1'b0);
    chk("t4_locked", 32'(locked), 1);
    for (int i = 18; i < 22; i++) begin
      step(1'b1, seq[i], 1'b0);
      chk($sformatf("t4_pulse%0d", i), 32'(pulse), 1);
      chk($sformatf("t4_lk%0d", i), 32'(locked), (i == 21) ? 0 : 1);
    end
    chk("t4_count", 32'(cnt), 4);
    for (int i = 22; i < 26; i++) begin
      step(1'b1, seq[i], 1'b0);
      chk($sformatf("t4_relk%0d", i), 32'(locked), (i == 25) ? 1 : 0);
      chk($sformatf("t4_rp%0d", i), 32'(pulse), 0);
    end
    chk("t4_count_hold", 32'(cnt), 4);

    // ---- 5: 2-bit counter saturates at 3; clear beats coincident miss
    do_reset();
    lock_up();
    chk("t5_locked", 32'(locked_s), 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, seq[15 + i], 1'b0);
      chk($sformatf("t5_sat%0d", i), 32'(cnt_s), (i < 3) ? i + 1 : 3);
    end
    chk("t5_still_lock", 32'(locked_s), 1);
    step(1'b1, seq[20], 1'b1);
    chk("t5_clr_count", 32'(cnt_s),   0);
    chk("t5_clr_pulse", 32'(pulse_s), 1);
    step(1'b1, seq[21], 1'b0);
    chk("t5_after_clr", 32'(cnt_s), 1);

    // ---- 6: enable toggling on a correct stream, then async reset mid-lock
    do_reset();
    lock_up();
    for (int i = 5; i < 15; i++) begin
      step(1'b0, 5'h1F, 1'b0);
      chk($sformatf("t6_idle%0d", i), 32'(pulse), 0);
      step(1'b1, seq[i], 1'b0);
      chk($sformatf("t6_en%0d", i), 32'(pulse), 0);
    end
    chk("t6_locked", 32'(locked), 1);
    chk("t6_count",  32'(cnt),    0);
    step(1'b1, 5'h1F, 1'b0);
    chk("t6_miss_count", 32'(cnt), 1);
    en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_locked", 32'(locked), 0);
    chk("t6_async_count",  32'(cnt),    0);
    chk("t6_async_pulse",  32'(pulse),  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, 5'h00, 1'b0);
    chk("t6_post_locked", 32'(locked), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
